minimig_autoconfig_ctrl: RTL
============================

Name: minimig_autoconfig_ctrl

Overview:
- Bus-side autoconfig responder and sequencer that reads the autoconfig nibble ROM.
- Maps CPU accesses in the $E80000 autoconfig window onto the ROM image of the board currently being configured.
- Captures base-address writes and shut-up writes, then advances the chain through Z2 RAM, Z3 RAM, Z3 RAM 2, Z3 RAM 3 and Ethernet.
- Sits between the CPU bus decoder and the ROM read port, and exports per-board base addresses to the memory and Ethernet decoders.

Parameters:
- ROM_LAT, 2, ROM read latency in clocks from rom_addr to valid rom_q.
- NBOARDS, 5, number of ROM board slots. Slot n starts at ROM word n*64.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- board_en  in  5  slot enables [z2, z3a, z3b, z3c, eth]; sampled only while reset is high
- req  in  1  CPU access request to the autoconfig window; held high until ack
- wr  in  1  1 = write, 0 = read; stable while req is high
- addr  in  6  CPU A[6:1]
- wdata  in  16  CPU write data
- ack  out  1  access complete; held high until req falls
- rdata  out  16  read data
- rom_addr  out  9  ROM read address
- rom_q  in  4  ROM nibble
- z2_base  out  8  Z2 base address, A23:A16
- z3a_base, z3b_base, z3c_base, eth_base  out  16 each  Z3 base addresses, A31:A16
- cfg_done  out  5  per-slot configured flag; set only by a base write, not by shut-up
- chain_done  out  1  every enabled slot is either configured or shut up

Behaviour:
- Reset: ack=0, rdata=0, all bases=0, cfg_done=0, state=IDLE, en_q<=board_en.
  - cur = lowest set bit of en_q. chain_done=1 if en_q==0.
- rom_addr = {cur[2:0], addr} combinationally.
- Read FSM: IDLE -> ROMW (count ROM_LAT cycles) -> ACK.
  - In the final ROMW cycle, rdata <= {rom_q, 12'hFFF}. ROM nibbles are stored in bus-ready form and are passed through unmodified.
  - ack rises exactly ROM_LAT+1 cycles after the first cycle req is seen in IDLE.
  - If chain_done=1: rdata=16'hFFFF and the latency is unchanged.
- Write: IDLE -> ACK, with ack high on the next clock.
  - The write takes effect on that same edge: the register update happens at the IDLE->ACK edge.
- ACK -> IDLE when req is low. ack deasserts on that edge. A new req is accepted no earlier than the following cycle.
- Writes to the Z2 slot (cur=0):
  - Offset $4A (addr=6'h25): latch wdata[15:12] into z2_base[3:0].
  - Offset $48 (addr=6'h24): z2_base[7:4] <= wdata[15:12], set cfg_done[0], advance.
- Writes to Z3 slots (cur=1..4):
  - Offset $44 (addr=6'h22): base <= wdata[15:0], set cfg_done[cur], advance.
  - Offset $48 byte writes to Z3 slots are ignored.
- Writes to $4C (addr=6'h26) on any slot: shut-up. Advance with cfg_done unchanged.
- Any other write offset, and any write while chain_done=1: acknowledged, no effect.
- Advance:
  - cur <= next set bit of en_q above cur.
  - If there is none: chain_done <= 1 and cur is held.
  - The new cur takes effect on the write edge, so the next read already addresses the new slot.
- Reset mid-access (including in ROMW or ACK): immediate return to reset values. req is ignored during the reset cycle.
- Base outputs are stable except on their own config write; a repeated chain pass is impossible without reset.

Decomposition:
- Package minimig_autoconfig_pkg:
  - slot index constants SLOT_Z2=0 .. SLOT_ETH=4;
  - register offset constants AC_Z3BASE=6'h22, AC_BASEHI=6'h24, AC_BASELO=6'h25, AC_SHUTUP=6'h26;
  - FSM state encoding.
- Sub-module minimig_autoconfig_next: combinational priority finder. Inputs en_q and cur; outputs next index and none flag.

Test Plan:
- board_en=5'b11111 with reset, then read addr=0 -> rom_addr=9'h000; ack 3 cycles after req; rdata[15:12]=4'hE (Z2 type nibble).
- Z2: write $4A wdata=16'h0000, then $48 wdata=16'h2000 -> z2_base=8'h20, cfg_done=5'b00001. Next read of addr 0 -> rom_addr=9'h040, rdata[15:12]=4'hA.
- Z3a: write $44 wdata=16'h4000 -> z3a_base=16'h4000. Then $4C shut-up on z3b -> cfg_done[2]=0 and cur=3 (rom_addr base 9'h0C0).
- board_en=5'b10001: configure Z2, then read addr=0 -> rom_addr=9'h100. Write $44 16'h4400 -> eth_base=16'h4400, chain_done=1. A subsequent read returns 16'hFFFF with latency unchanged.
- board_en=0 -> chain_done=1 out of reset. Reads return 16'hFFFF; writes are acked with no state change.
- Assert reset while in ROMW -> next cycle ack=0, bases=0, cur=lowest enabled slot. A req held high is processed normally after reset deasserts.

Source files
------------

// File: rtl/minimig_autoconfig_pkg.sv
// rtl/minimig_autoconfig_pkg.sv - slot indices, register offsets and FSM encoding for the autoconfig responder
package minimig_autoconfig_pkg;

  localparam logic [2:0] SLOT_Z2  = 3'd0;
  localparam logic [2:0] SLOT_Z3A = 3'd1;
  localparam logic [2:0] SLOT_Z3B = 3'd2;
  localparam logic [2:0] SLOT_Z3C = 3'd3;
  localparam logic [2:0] SLOT_ETH = 3'd4;

  localparam logic [5:0] AC_Z3BASE = 6'h22;
  localparam logic [5:0] AC_BASEHI = 6'h24;
  localparam logic [5:0] AC_BASELO = 6'h25;
  localparam logic [5:0] AC_SHUTUP = 6'h26;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROMW = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/minimig_autoconfig_next.sv
// rtl/minimig_autoconfig_next.sv - finds the lowest enabled slot strictly above the current one
module minimig_autoconfig_next
  import minimig_autoconfig_pkg::*;
#(
  parameter int NBOARDS = 5
) (
  input  logic [NBOARDS-1:0] en_i,
  input  logic [2:0]         cur_i,
  output logic [2:0]         next_o,
  output logic               none_o
);

  // Scanning downwards lets the lowest qualifying slot win.
  always_comb begin
    next_o = cur_i;
    none_o = 1'b1;
    for (int i = NBOARDS - 1; i >= 0; i--) begin
      if (en_i[i] && (3'(i) > cur_i)) begin
        next_o = 3'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/minimig_autoconfig_ctrl.sv
// rtl/minimig_autoconfig_ctrl.sv - autoconfig window responder: serves ROM nibbles and sequences the board chain
module minimig_autoconfig_ctrl
  import minimig_autoconfig_pkg::*;
#(
  parameter int ROM_LAT = 2,
  parameter int NBOARDS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NBOARDS-1:0] board_en,
  input  logic               req,
  input  logic               wr,
  input  logic [5:0]         addr,
  input  logic [15:0]        wdata,
  output logic               ack,
  output logic [15:0]        rdata,
  output logic [8:0]         rom_addr,
  input  logic [3:0]         rom_q,
  output logic [7:0]         z2_base,
  output logic [15:0]        z3a_base,
  output logic [15:0]        z3b_base,
  output logic [15:0]        z3c_base,
  output logic [15:0]        eth_base,
  output logic [NBOARDS-1:0] cfg_done,
  output logic               chain_done
);

  localparam int CNT_W = $clog2(ROM_LAT + 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NBOARDS-1:0] en_q;
  logic [2:0]         cur_q, cur_d;
  logic               chain_done_q, chain_done_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [7:0]         z2_base_q, z2_base_d;
  logic [15:0]        z3a_q, z3a_d, z3b_q, z3b_d, z3c_q, z3c_d, eth_q, eth_d;
  logic [NBOARDS-1:0] cfg_done_q, cfg_done_d;
  logic [2:0]         nxt_idx, first_idx;
  logic               nxt_none, advance, cfg_set;

  minimig_autoconfig_next #(.NBOARDS(NBOARDS)) u_next (
    .en_i   (en_q),
    .cur_i  (cur_q),
    .next_o (nxt_idx),
    .none_o (nxt_none)
  );

  // Starting slot is taken straight from board_en since en_q loads on the same edge.
  always_comb begin
    first_idx = 3'd0;
    for (int i = NBOARDS - 1; i >= 0; i--) begin
      if (board_en[i]) first_idx = 3'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    chain_done_d = chain_done_q;
    rdata_d      = rdata_q;
    z2_base_d    = z2_base_q;
    z3a_d        = z3a_q;
    z3b_d        = z3b_q;
    z3c_d        = z3c_q;
    eth_d        = eth_q;
    cfg_done_d   = cfg_done_q;
    advance      = 1'b0;
    cfg_set      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && wr) begin
          state_d = ST_ACK;
          if (!chain_done_q) begin
            if (addr == AC_SHUTUP) begin
              advance = 1'b1;
            end else if (cur_q == SLOT_Z2) begin
              if (addr == AC_BASELO) begin
                z2_base_d[3:0] = wdata[15:12];
              end else if (addr == AC_BASEHI) begin
                z2_base_d[7:4] = wdata[15:12];
                cfg_set        = 1'b1;
                advance        = 1'b1;
              end
            end else if (addr == AC_Z3BASE) begin
              case (cur_q)
                SLOT_Z3A: z3a_d = wdata;
                SLOT_Z3B: z3b_d = wdata;
                SLOT_Z3C: z3c_d = wdata;
                SLOT_ETH: eth_d = wdata;
                default: ;
              endcase
              cfg_set = 1'b1;
              advance = 1'b1;
            end
          end
        end else if (req) begin
          state_d = ST_ROMW;
          cnt_d   = '0;
        end
      end
      ST_ROMW: begin
        if (cnt_q == CNT_W'(ROM_LAT - 1)) begin
          rdata_d = chain_done_q ? 16'hFFFF : {rom_q, 12'hFFF};
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cfg_set) cfg_done_d[cur_q] = 1'b1;
    if (advance) begin
      if (nxt_none) chain_done_d = 1'b1;
      else          cur_d        = nxt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      en_q         <= board_en;
      cur_q        <= first_idx;
      chain_done_q <= (board_en == '0);
      rdata_q      <= '0;
      z2_base_q    <= '0;
      z3a_q        <= '0;
      z3b_q        <= '0;
      z3c_q        <= '0;
      eth_q        <= '0;
      cfg_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      chain_done_q <= chain_done_d;
      rdata_q      <= rdata_d;
      z2_base_q    <= z2_base_d;
      z3a_q        <= z3a_d;
      z3b_q        <= z3b_d;
      z3c_q        <= z3c_d;
      eth_q        <= eth_d;
      cfg_done_q   <= cfg_done_d;
    end
  end

  assign rom_addr   = {cur_q, addr};
  assign ack        = (state_q == ST_ACK);
  assign rdata      = rdata_q;
  assign z2_base    = z2_base_q;
  assign z3a_base   = z3a_q;
  assign z3b_base   = z3b_q;
  assign z3c_base   = z3c_q;
  assign eth_base   = eth_q;
  assign cfg_done   = cfg_done_q;
  assign chain_done = chain_done_q;

endmodule
